cnt_seq_ctrl: RTL and testbench
===============================

# cnt_seq_ctrl

Programmable sequencer for the team's 4-bit up/down counter.
- Holds a small program of counting segments. Each segment has a direction, a MIN/MAX window and a lap count.
- Drives the counter's load, stop/start and configuration inputs to run the segments back to back.
- Watches the counter's output to know when each lap and segment finishes.
- Sits between a host, which writes the program and issues START, and one counter instance.

## Interface
- W, 4, counter width (MIN/MAX/CNT_Q)
- LW, 4, lap-count field width
- NSEG, 4, program depth (segments)
- AW, 2, program address width, clog2(NSEG)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- WE  in  1  program write strobe; ignored while BUSY=1
- WADDR  in  AW  segment index to write
- WDATA  in  2W+LW+1  segment word: [2W+LW]=MODE (1 up, 0 down), [2W+LW-1:W+LW]=MIN, [W+LW-1:LW]=MAX, [LW-1:0]=LAPS
- START  in  1  start the program; sampled only in IDLE or DONE
- HOLD  in  1  pause while in RUN
- ABORT  in  1  stop immediately, from any state
- CNT_Q  in  W  counter's current value
- CNT_LD  out  1  counter load strobe; counter takes MIN (up) or MAX (down) on the edge where CNT_LD=1
- CNT_SS  out  1  counter step enable; the counter wraps at its end value
- CNT_MODE  out  1  MODE field of the segment selected by SEG
- CNT_MIN, CNT_MAX  out  W each  MIN and MAX fields of the segment selected by SEG
- SEG  out  AW  active segment index
- LAP  out  LW  laps completed in the active segment
- BUSY  out  1  high in LOAD and RUN
- DONE  out  1  one-cycle pulse when the program completes

## Operation
- **Program storage**
  - NSEG registers, written on the edge where WE=1 and BUSY=0.
  - Reset clears every entry to 0.
- **Valid segment:** LAPS≠0 and MIN≤MAX. Invalid segments are skipped and cost zero cycles.
- **End value:** MAX when MODE=1, MIN when MODE=0.
- **FSM states:** IDLE, LOAD, RUN, DONE.
  - **IDLE/DONE, START=1:**
    - Go to LOAD with SEG = lowest valid index.
    - If no valid segment exists, go to DONE instead.
  - **LOAD:**
    - CNT_LD=1, CNT_SS=0, LAP cleared to 0.
    - Next state is always RUN.
  - **RUN, HOLD=1:** CNT_SS=0; LAP and state are unchanged.
  - **RUN, HOLD=0:** CNT_SS=1.
    - If CNT_Q equals the end value, the lap completes: LAP increments.
    - If the incremented LAP equals LAPS, the segment ends:
      - go to LOAD with SEG = next higher valid index, or
      - go to DONE if there is none.
  - **DONE:** DONE=1, BUSY=0. Next state is LOAD on START (as in IDLE), otherwise IDLE.
- **ABORT=1:**
  - Next state is IDLE, with SEG=0 and LAP=0.
  - No DONE pulse.
  - ABORT has priority over START and HOLD.
- **Configuration outputs:**
  - CNT_MODE/MIN/MAX are combinational from entry[SEG].
  - CNT_LD, CNT_SS and BUSY decode the state.
  - SEG, LAP and DONE are registered.
- **Cycle cost:**
  - Each lap takes MAX−MIN+1 RUN cycles with HOLD low.
  - A segment takes 1 + LAPS·(MAX−MIN+1) cycles.
- **Lap arithmetic:**
  - LAP is LW bits.
  - LAPS=2^LW−1 is legal, and the compare reaches it without overflow.

## Timing
- **Reset values:** state IDLE; CNT_LD=0, CNT_SS=0, SEG=0, LAP=0, BUSY=0, DONE=0; program entries 0.
  - CNT_MODE/MIN/MAX therefore read 0.
- **Reset mid-run:** same values, taking effect asynchronously. The counter then stops stepping because CNT_SS=0.
- **Start latency:** START sampled at edge E0 → LOAD during the cycle after E0 → first RUN cycle after E1.
- **CNT_Q assumption:** CNT_Q is the counter's registered value and is current in the same cycle. After the LOAD edge, CNT_Q equals the start value.
- **Simultaneous events:**
  - START while BUSY: ignored.
  - WE while BUSY: ignored, and the program is unchanged.
  - WE and START on the same edge in IDLE: the write lands and the run starts. The written entry is used if it is reached.
  - HOLD in LOAD: no effect; LOAD always lasts exactly one cycle.

## Test plan
- **Basic two-segment run**
  - Stimulus: reset; write seg0={1,2,5,2}, seg1={0,0,3,1}, seg2=seg3=0; START at E0.
  - Required: LOAD cycle 1; RUN cycles 2–9 with CNT_Q 2,3,4,5,2,3,4,5; LOAD cycle 10; RUN cycles 11–14 with CNT_Q 3,2,1,0; DONE high for one cycle after E14; BUSY high for cycles 1–14 only.
- **Skipping and empty program**
  - Stimulus: seg0 LAPS=0; seg1 has MIN=6, MAX=3; seg2={1,0,1,1}.
  - Required: the first LOAD has SEG=2; DONE arrives 3 cycles later.
  - Stimulus: an all-zero program, then START.
  - Required: DONE on the next cycle with no LOAD.
- **HOLD**
  - Stimulus: raise HOLD for 3 cycles mid-lap of seg0={1,2,5,2}.
  - Required: CNT_SS=0 and LAP frozen during HOLD; DONE 3 cycles later than the unheld run.
- **ABORT**
  - Stimulus: ABORT during RUN at LAP=1.
  - Required: IDLE next cycle; SEG=0, LAP=0, BUSY=0, no DONE.
  - Stimulus: ABORT and START together in IDLE.
  - Required: stays in IDLE.
- **Reset and write protection**
  - Stimulus: WE to seg1 while BUSY.
  - Required: the entry is unchanged, checked by a later run.
  - Stimulus: rst low asynchronously mid-RUN.
  - Required: all outputs go to their reset values immediately; the program is cleared.
- **Maximal segment**
  - Stimulus: seg0={1,0,15,15}.
  - Required: 240 RUN cycles and LAP reaches 15 without overflow; DONE at cycle 242.

Source files
------------

// File: rtl/cnt_seq_ctrl.sv
// -----------------------------------------------------------------------------
// cnt_seq_ctrl
//   Programmable sequencer for a 4-bit up/down counter. Holds NSEG counting
//   segments (direction, MIN/MAX window, lap count). On START it runs the valid
//   segments back to back, loading the counter at the start of each segment
//   and watching CNT_Q to count laps.
//
// Ports
//   clk       clock, all state updates on the rising edge
//   rst       asynchronous reset, active low
//   we        program write strobe (ignored while busy)
//   waddr     segment index to write
//   wdata     segment word {mode, min, max, laps}
//   start     start the program (sampled in IDLE or DONE)
//   hold      pause stepping while in RUN
//   abort     return to IDLE immediately, from any state
//   cnt_q     counter's current registered value
//   cnt_ld    counter load strobe (counter takes MIN when up, MAX when down)
//   cnt_ss    counter step enable
//   cnt_mode  mode field of the active segment (1 up, 0 down)
//   cnt_min   min field of the active segment
//   cnt_max   max field of the active segment
//   seg       active segment index
//   lap       laps completed in the active segment
//   busy      high in LOAD and RUN
//   done      one-cycle pulse when the program completes
// -----------------------------------------------------------------------------
module cnt_seq_ctrl #(
    parameter int W    = 4,
    parameter int LW   = 4,
    parameter int NSEG = 4,
    parameter int AW   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [2*W+LW:0]   wdata,
    input  logic              start,
    input  logic              hold,
    input  logic              abort,
    input  logic [W-1:0]      cnt_q,
    output logic              cnt_ld,
    output logic              cnt_ss,
    output logic              cnt_mode,
    output logic [W-1:0]      cnt_min,
    output logic [W-1:0]      cnt_max,
    output logic [AW-1:0]     seg,
    output logic [LW-1:0]     lap,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, FIN} state_t;

    typedef struct packed {
        logic          mode;
        logic [W-1:0]  lo;
        logic [W-1:0]  hi;
        logic [LW-1:0] laps;
    } seg_t;

    state_t          state, state_nxt;
    seg_t            prog [NSEG];
    seg_t            eff  [NSEG];
    seg_t            cur;
    logic [NSEG-1:0] valid;
    logic            first_found, next_found;
    logic [AW-1:0]   first_idx, next_idx;
    logic [AW-1:0]   seg_nxt;
    logic [LW-1:0]   lap_nxt;
    logic [LW:0]     lap_inc;
    logic            seg_end;
    logic [W-1:0]    end_val;

    // Program storage.
    // NOTE: the program registers are reset along with the control state, so a
    // START straight after reset sees an all-invalid program and finishes at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NSEG; i++) prog[i] <= '0;
        end else if (we && !busy) begin
            prog[waddr] <= seg_t'(wdata);
        end
    end

    // A write landing on the same edge as START must be visible to the
    // first-segment search, so validity is judged on the forwarded program.
    always_comb begin
        for (int i = 0; i < NSEG; i++) begin
            eff[i]   = (we && !busy && waddr == AW'(i)) ? seg_t'(wdata) : prog[i];
            valid[i] = (eff[i].laps != '0) && (eff[i].lo <= eff[i].hi);
        end
    end

    // Lowest valid index overall, and lowest valid index above the active one.
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        for (int i = NSEG - 1; i >= 0; i--) begin
            if (valid[i]) begin
                first_found = 1'b1;
                first_idx   = AW'(i);
            end
            if (valid[i] && (i > int'(seg))) begin
                next_found = 1'b1;
                next_idx   = AW'(i);
            end
        end
    end

    assign cur      = prog[seg];
    assign cnt_mode = cur.mode;
    assign cnt_min  = cur.lo;
    assign cnt_max  = cur.hi;
    assign end_val  = cur.mode ? cur.hi : cur.lo;
    assign busy     = (state == LOAD) || (state == RUN);

    // One extra bit keeps the compare exact when LAPS is all ones.
    assign lap_inc  = {1'b0, lap} + 1'b1;
    assign seg_end  = (lap_inc == {1'b0, cur.laps});

    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        seg_nxt   = seg;
        lap_nxt   = lap;
        cnt_ld    = 1'b0;
        cnt_ss    = 1'b0;
        case (state)
            IDLE, FIN: begin
                state_nxt = IDLE;
                if (start) begin
                    if (first_found) begin
                        state_nxt = LOAD;
                        seg_nxt   = first_idx;
                        lap_nxt   = '0;
                    end else begin
                        state_nxt = FIN;
                    end
                end
            end
            LOAD: begin
                cnt_ld    = 1'b1;
                lap_nxt   = '0;
                state_nxt = RUN;
            end
            RUN: begin
                if (!hold) begin
                    cnt_ss = 1'b1;
                    if (cnt_q == end_val) begin
                        lap_nxt = lap_inc[LW-1:0];
                        if (seg_end) begin
                            if (next_found) begin
                                state_nxt = LOAD;
                                seg_nxt   = next_idx;
                                lap_nxt   = '0;
                            end else begin
                                state_nxt = FIN;
                            end
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt = IDLE;
            seg_nxt   = '0;
            lap_nxt   = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            seg   <= '0;
            lap   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            seg   <= seg_nxt;
            lap   <= lap_nxt;
            done  <= (state_nxt == FIN);
        end
    end

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cnt_seq_ctrl
//   Directed bench for cnt_seq_ctrl with a behavioural 4-bit up/down counter.
//   Each expected cycle (inputs to apply plus outputs to see) is pushed to a
//   scoreboard queue; drain() applies the inputs and compares the outputs.
// -----------------------------------------------------------------------------
module tb_cnt_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [1:0]  waddr;
    logic [12:0] wdata;
    logic        start, hold, abort;
    logic [3:0]  cnt_q = 4'd0;
    logic        cnt_ld, cnt_ss, cnt_mode;
    logic [3:0]  cnt_min, cnt_max;
    logic [1:0]  seg;
    logic [3:0]  lap;
    logic        busy, done;

    int checks = 0;
    int errors = 0;
    int step   = 0;

    typedef struct {
        bit          ld, ss, bsy, dn;
        logic [1:0]  sg;
        logic [3:0]  lp;
        bit          cq;
        logic [3:0]  q;
        bit          st, h, a, w;
        logic [1:0]  wa;
        logic [12:0] wd;
    } exp_t;

    exp_t sb[$];

    cnt_seq_ctrl dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .start(start), .hold(hold), .abort(abort), .cnt_q(cnt_q),
        .cnt_ld(cnt_ld), .cnt_ss(cnt_ss), .cnt_mode(cnt_mode),
        .cnt_min(cnt_min), .cnt_max(cnt_max), .seg(seg), .lap(lap),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Behavioural counter: load has priority, stepping wraps at the end value.
    always @(posedge clk) begin
        if (cnt_ld)
            cnt_q <= cnt_mode ? cnt_min : cnt_max;
        else if (cnt_ss) begin
            if (cnt_mode) cnt_q <= (cnt_q == cnt_max) ? cnt_min : cnt_q + 4'd1;
            else          cnt_q <= (cnt_q == cnt_min) ? cnt_max : cnt_q - 4'd1;
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step, obs, exp);
        end
    endtask

    function automatic logic [12:0] sw(input bit m, input logic [3:0] mn,
                                       input logic [3:0] mx, input logic [3:0] lp);
        return {m, mn, mx, lp};
    endfunction

    function automatic void push(input bit ld, input bit ss, input bit bsy, input bit dn,
                                 input logic [1:0] sg, input logic [3:0] lp,
                                 input bit cq, input logic [3:0] q);
        exp_t e;
        e.ld = ld; e.ss = ss; e.bsy = bsy; e.dn = dn; e.sg = sg; e.lp = lp;
        e.cq = cq; e.q = q;
        e.st = 1'b0; e.h = 1'b0; e.a = 1'b0; e.w = 1'b0; e.wa = '0; e.wd = '0;
        sb.push_back(e);
    endfunction

    function automatic void push_idle(input int n, input logic [1:0] sg, input logic [3:0] lp);
        for (int i = 0; i < n; i++) push(0, 0, 0, 0, sg, lp, 0, 4'd0);
    endfunction

    function automatic void push_done(input logic [1:0] sg, input logic [3:0] lp);
        push(0, 0, 0, 1, sg, lp, 0, 4'd0);
    endfunction

    // Idle cycle with START applied.
    function automatic void start_rec(input logic [1:0] sg, input logic [3:0] lp);
        push_idle(1, sg, lp);
        sb[sb.size() - 1].st = 1'b1;
    endfunction

    // One segment: a LOAD cycle, then LAPS laps of MAX-MIN+1 RUN cycles.
    // Optionally hold for hold_len cycles before RUN cycle hold_at, or abort
    // on RUN cycle abort_at (followed by one IDLE cycle with SEG=0, LAP=0).
    function automatic void push_seg(input logic [1:0] sg, input bit mode,
                                     input logic [3:0] mn, input logic [3:0] mx,
                                     input logic [3:0] laps, input int hold_at,
                                     input int hold_len, input int abort_at);
        int len = int'(mx) - int'(mn) + 1;
        int k   = 0;
        logic [3:0] q;
        push(1, 0, 1, 0, sg, 4'd0, 0, 4'd0);
        for (int l = 0; l < int'(laps); l++) begin
            for (int i = 0; i < len; i++) begin
                q = mode ? 4'(int'(mn) + i) : 4'(int'(mx) - i);
                if (k == hold_at) begin
                    for (int j = 0; j < hold_len; j++) begin
                        push(0, 0, 1, 0, sg, 4'(l), 1, q);
                        sb[sb.size() - 1].h = 1'b1;
                    end
                end
                push(0, 1, 1, 0, sg, 4'(l), 1, q);
                if (k == abort_at) begin
                    sb[sb.size() - 1].a = 1'b1;
                    push_idle(1, 2'd0, 4'd0);
                    return;
                end
                k++;
            end
        end
    endfunction

    // Apply and check up to n scoreboard entries, one per clock cycle.
    task automatic drain(input int n);
        exp_t e;
        int   cnt = 0;
        while (sb.size() != 0 && cnt < n) begin
            e = sb.pop_front();
            cnt++;
            step++;
            start = e.st; hold = e.h; abort = e.a;
            we = e.w; waddr = e.wa; wdata = e.wd;
            #1;
            chk("cnt_ld", 16'(cnt_ld), 16'(e.ld));
            chk("cnt_ss", 16'(cnt_ss), 16'(e.ss));
            chk("busy",   16'(busy),   16'(e.bsy));
            chk("done",   16'(done),   16'(e.dn));
            chk("seg",    16'(seg),    16'(e.sg));
            chk("lap",    16'(lap),    16'(e.lp));
            if (e.cq) chk("cnt_q", 16'(cnt_q), 16'(e.q));
            @(negedge clk);
        end
        start = 1'b0; hold = 1'b0; abort = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [12:0] d);
        we = 1'b1; waddr = a; wdata = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_cnt_ld", 16'(cnt_ld),   16'd0);
        chk("rst_cnt_ss", 16'(cnt_ss),   16'd0);
        chk("rst_busy",   16'(busy),     16'd0);
        chk("rst_done",   16'(done),     16'd0);
        chk("rst_seg",    16'(seg),      16'd0);
        chk("rst_lap",    16'(lap),      16'd0);
        chk("rst_mode",   16'(cnt_mode), 16'd0);
        chk("rst_min",    16'(cnt_min),  16'd0);
        chk("rst_max",    16'(cnt_max),  16'd0);
    endtask

    initial begin
        rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
        start = 1'b0; hold = 1'b0; abort = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_reset_outputs();
        @(negedge clk);
        rst = 1'b1;

        // Basic two-segment run; START and a seg1 write while busy are ignored.
        wr(2'd0, sw(1, 4'd2, 4'd5, 4'd2));
        wr(2'd1, sw(0, 4'd0, 4'd3, 4'd1));
        start_rec(2'd0, 4'd0);
        push_seg(2'd0, 1, 4'd2, 4'd5, 4'd2, -1, 0, -1);
        sb[4].st = 1'b1;
        sb[5].w  = 1'b1; sb[5].wa = 2'd1; sb[5].wd = sw(1, 4'd0, 4'd1, 4'd1);
        push_seg(2'd1, 0, 4'd0, 4'd3, 4'd1, -1, 0, -1);
        push_done(2'd1, 4'd1);
        push_idle(2, 2'd1, 4'd1);
        drain(1000);

        // HOLD for three cycles mid-lap; everything after shifts by three.
        start_rec(2'd1, 4'd1);
        push_seg(2'd0, 1, 4'd2, 4'd5, 4'd2, 2, 3, -1);
        push_seg(2'd1, 0, 4'd0, 4'd3, 4'd1, -1, 0, -1);
        push_done(2'd1, 4'd1);
        push_idle(1, 2'd1, 4'd1);
        drain(1000);

        // ABORT at LAP=1, then ABORT together with START in IDLE.
        start_rec(2'd1, 4'd1);
        push_seg(2'd0, 1, 4'd2, 4'd5, 4'd2, -1, 0, 5);
        start_rec(2'd0, 4'd0);
        sb[sb.size() - 1].a = 1'b1;
        push_idle(3, 2'd0, 4'd0);
        drain(1000);

        // Skipping: seg0 LAPS=0, seg1 MIN>MAX, seg2 valid.
        wr(2'd0, sw(1, 4'd2, 4'd5, 4'd0));
        wr(2'd1, sw(1, 4'd6, 4'd3, 4'd1));
        wr(2'd2, sw(1, 4'd0, 4'd1, 4'd1));
        start_rec(2'd0, 4'd0);
        push_seg(2'd2, 1, 4'd0, 4'd1, 4'd1, -1, 0, -1);
        push_done(2'd2, 4'd1);
        push_idle(1, 2'd2, 4'd1);
        drain(1000);

        // Empty program: DONE on the next cycle, no LOAD.
        wr(2'd2, 13'd0);
        start_rec(2'd2, 4'd1);
        push_done(2'd2, 4'd1);
        push_idle(1, 2'd2, 4'd1);
        drain(1000);

        // Write and START on the same edge: the new entry is run.
        start_rec(2'd2, 4'd1);
        sb[sb.size() - 1].w  = 1'b1;
        sb[sb.size() - 1].wa = 2'd0;
        sb[sb.size() - 1].wd = sw(1, 4'd0, 4'd1, 4'd1);
        push_seg(2'd0, 1, 4'd0, 4'd1, 4'd1, -1, 0, -1);
        push_done(2'd0, 4'd1);
        push_idle(1, 2'd0, 4'd1);
        drain(1000);

        // Maximal segment: 240 RUN cycles, LAP reaches 15, DONE at cycle 242.
        wr(2'd0, sw(1, 4'd0, 4'd15, 4'd15));
        start_rec(2'd0, 4'd1);
        push_seg(2'd0, 1, 4'd0, 4'd15, 4'd15, -1, 0, -1);
        push_done(2'd0, 4'd15);
        push_idle(1, 2'd0, 4'd15);
        drain(1000);

        // Asynchronous reset mid-RUN, then an empty-program run shows the clear.
        wr(2'd0, sw(1, 4'd2, 4'd5, 4'd2));
        start_rec(2'd0, 4'd15);
        push_seg(2'd0, 1, 4'd2, 4'd5, 4'd2, -1, 0, -1);
        drain(5);
        sb.delete();
        #2 rst = 1'b0;
        #1;
        chk_reset_outputs();
        @(negedge clk);
        rst = 1'b1;
        start_rec(2'd0, 4'd0);
        push_done(2'd0, 4'd0);
        push_idle(1, 2'd0, 4'd0);
        drain(1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
